// File: rtl/adc_frontend_pkg.sv
// Shared types, default parameters and the saturation helper for the ADC front end.
package adc_frontend_pkg;

  localparam int DEF_CLK_REF     = 50_000_000;
  localparam int DEF_SAMPL_T     = 1_000_000;
  localparam int DEF_WIDTH       = 14;
  localparam int DEF_CAL_LOG2    = 8;
  localparam int DEF_TRACK_SHIFT = 10;
  localparam int T               = DEF_CLK_REF / DEF_SAMPL_T;

  typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

  typedef struct packed {
    logic               clamp;
    logic signed [31:0] val;
  } sat_t;

  // Clamp a sign-extended (w+1)-bit difference into the w-bit two's complement range.
  function automatic sat_t sat_w(input logic signed [31:0] d, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sat_t r;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    r.clamp = 1'b0;
    r.val   = d;
    if (d > hi) begin
      r.clamp = 1'b1;
      r.val   = hi;
    end else if (d < lo) begin
      r.clamp = 1'b1;
      r.val   = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_frontend_if.sv
// Sample/control bundle between the ADC front end (slave) and its controller/consumer (master).
interface adc_frontend_if #(parameter int WIDTH = 14);
  logic signed [WIDTH-1:0] adc_i_raw;
  logic signed [WIDTH-1:0] adc_u_raw;
  logic                    run_en;
  logic                    cal_req;
  logic                    ovr_clr;
  logic signed [WIDTH-1:0] signal_adc_I;
  logic signed [WIDTH-1:0] signal_adc_U;
  logic                    out_valid;
  logic                    cal_busy;
  logic                    ovr_i;
  logic                    ovr_u;

  modport master (
    output adc_i_raw, adc_u_raw, run_en, cal_req, ovr_clr,
    input  signal_adc_I, signal_adc_U, out_valid, cal_busy, ovr_i, ovr_u
  );

  modport slave (
    input  adc_i_raw, adc_u_raw, run_en, cal_req, ovr_clr,
    output signal_adc_I, signal_adc_U, out_valid, cal_busy, ovr_i, ovr_u
  );
endinterface

// File: rtl/adc_frontend_chan.sv
// One ADC channel: capture, calibration accumulator, offset removal, saturation, sticky overrange.
// Optional DC tracker built when ADC_FRONTEND_TRACK_EN is defined.
module adc_chan import adc_frontend_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CAL_LOG2 = DEF_CAL_LOG2
`ifdef ADC_FRONTEND_TRACK_EN
  , parameter int TRACK_SHIFT = DEF_TRACK_SHIFT
`endif
) (
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic signed [WIDTH-1:0] raw,
  input  logic                    tick,
  input  logic                    samp,
  input  logic                    cal_start,
  input  logic                    cal_done,
  input  logic                    ovr_clr,
  input  state_t                  state,
  output logic signed [WIDTH-1:0] sample,
  output logic                    ovr
);
  localparam int AW = WIDTH + CAL_LOG2;
  localparam logic signed [WIDTH-1:0] MAX_C = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_C = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] cap_q, cap_d, offset_q, offset_d, sample_q, sample_d, cal_off;
  logic signed [AW-1:0]    acc_q, acc_d, acc_sum;
  logic signed [WIDTH:0]   diff;
  logic                    ovr_q, ovr_d;
  sat_t                    sr;

`ifdef ADC_FRONTEND_TRACK_EN
  localparam int TW = WIDTH + TRACK_SHIFT;
  logic signed [TW-1:0] acc_t_q, acc_t_d, acc_t_sum;
`endif

  always_comb begin
    cap_d    = tick ? raw : cap_q;
    diff     = (WIDTH+1)'(cap_q) - (WIDTH+1)'(offset_q);
    sr       = sat_w(32'(diff), WIDTH);
    acc_sum  = acc_q + AW'(cap_q);
    cal_off  = WIDTH'(acc_sum >>> CAL_LOG2);
    acc_d    = acc_q;
    offset_d = offset_q;
    sample_d = sample_q;
    ovr_d    = ovr_clr ? 1'b0 : ovr_q;

    if (cal_start)
      acc_d = '0;
    else if (samp && state == CAL)
      acc_d = acc_sum;
    if (cal_done)
      offset_d = cal_off;

    // Clamping only counts when the corrected value actually reaches the output.
    if (samp) begin
      sample_d = (state == CAL) ? '0 : WIDTH'(sr.val);
      if (cap_q == MAX_C || cap_q == MIN_C || (sr.clamp && state != CAL))
        ovr_d = 1'b1;
    end

`ifdef ADC_FRONTEND_TRACK_EN
    acc_t_sum = acc_t_q + TW'(diff);
    acc_t_d   = acc_t_q;
    if (cal_done)
      acc_t_d = TW'(cal_off) <<< TRACK_SHIFT;
    else if (samp && state == RUN) begin
      acc_t_d  = acc_t_sum;
      offset_d = WIDTH'(acc_t_sum >>> TRACK_SHIFT);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cap_q    <= '0;
      acc_q    <= '0;
      offset_q <= '0;
      sample_q <= '0;
      ovr_q    <= 1'b0;
`ifdef ADC_FRONTEND_TRACK_EN
      acc_t_q  <= '0;
`endif
    end else begin
      cap_q    <= cap_d;
      acc_q    <= acc_d;
      offset_q <= offset_d;
      sample_q <= sample_d;
      ovr_q    <= ovr_d;
`ifdef ADC_FRONTEND_TRACK_EN
      acc_t_q  <= acc_t_d;
`endif
    end
  end

  assign sample = sample_q;
  assign ovr    = ovr_q;
endmodule

// File: rtl/adc_frontend.sv
// ADC front end top: sample tick counter, IDLE/CAL/RUN control FSM and two channel instances.
// Optional macro ADC_FRONTEND_TRACK_EN adds a leaky DC-offset tracker in RUN.
module adc_frontend import adc_frontend_pkg::*; #(
  parameter int CLK_REF  = DEF_CLK_REF,
  parameter int SAMPL_T  = DEF_SAMPL_T,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CAL_LOG2 = DEF_CAL_LOG2
`ifdef ADC_FRONTEND_TRACK_EN
  , parameter int TRACK_SHIFT = DEF_TRACK_SHIFT
`endif
) (
  input logic           clk,
  input logic           reset_l,
  adc_frontend_if.slave bus
);
  localparam int TS = CLK_REF / SAMPL_T;
  localparam int CW = (TS > 1) ? $clog2(TS) : 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CAL_LOG2-1:0] cal_cnt_q, cal_cnt_d;
  logic                tick, samp_q, samp_d, out_valid_q, out_valid_d, cal_start, cal_done;
  state_t              state_q, state_d;

  logic signed [WIDTH-1:0] raw_ch [2];
  logic signed [WIDTH-1:0] smp_ch [2];
  logic                    ovr_ch [2];

  always_comb begin
    tick        = bus.run_en && (cnt_q == CW'(TS - 1));
    cnt_d       = (!bus.run_en || tick) ? '0 : cnt_q + 1'b1;
    samp_d      = tick;
    out_valid_d = samp_q;
  end

  // samp_q marks the cycle in which the freshly captured sample is processed.
  always_comb begin
    state_d   = state_q;
    cal_cnt_d = cal_cnt_q;
    cal_start = 1'b0;
    cal_done  = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (bus.cal_req) begin
          state_d   = CAL;
          cal_start = 1'b1;
          cal_cnt_d = '0;
        end
      end
      CAL: begin
        if (samp_q) begin
          cal_cnt_d = cal_cnt_q + 1'b1;
          if (cal_cnt_q == '1) begin
            cal_done = 1'b1;
            state_d  = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q       <= '0;
      samp_q      <= 1'b0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
      cal_cnt_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      samp_q      <= samp_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      cal_cnt_q   <= cal_cnt_d;
    end
  end

  assign raw_ch[0] = bus.adc_i_raw;
  assign raw_ch[1] = bus.adc_u_raw;

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    adc_chan #(
      .WIDTH(WIDTH),
      .CAL_LOG2(CAL_LOG2)
`ifdef ADC_FRONTEND_TRACK_EN
      , .TRACK_SHIFT(TRACK_SHIFT)
`endif
    ) u_chan (
      .clk(clk),
      .reset_l(reset_l),
      .raw(raw_ch[gi]),
      .tick(tick),
      .samp(samp_q),
      .cal_start(cal_start),
      .cal_done(cal_done),
      .ovr_clr(bus.ovr_clr),
      .state(state_q),
      .sample(smp_ch[gi]),
      .ovr(ovr_ch[gi])
    );
  end

  assign bus.signal_adc_I = smp_ch[0];
  assign bus.signal_adc_U = smp_ch[1];
  assign bus.ovr_i        = ovr_ch[0];
  assign bus.ovr_u        = ovr_ch[1];
  assign bus.out_valid    = out_valid_q;
  assign bus.cal_busy     = (state_q == CAL);
endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend with T=50 clocks/sample and a 4-sample calibration window.
module tb_adc_frontend;
  logic clk;
  logic reset_l;
  int   checks;
  int   fails;
  int   n;
  int   pulses;
  logic signed [31:0] prev;

  int cal_i_tab [4] = '{11, 12, 13, 111};
  int cal_u_tab [4] = '{-3, -3, -2, 10};

  adc_frontend_if #(.WIDTH(14)) bus ();

  adc_frontend #(.CAL_LOG2(2)) dut (
    .clk(clk),
    .reset_l(reset_l),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of clock edges until out_valid is seen high (bounded).
  task automatic wait_pulse(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.out_valid && cnt < 200);
    checks++;
    assert (bus.out_valid === 1'b1) else begin
      fails++;
      $error("FAIL pulse_timeout: out_valid=%b after %0d clks, required 1", bus.out_valid, cnt);
    end
    $display("txn: valid after %0d clks I=%0d U=%0d busy=%b ovr_i=%b ovr_u=%b",
             cnt, bus.signal_adc_I, bus.signal_adc_U, bus.cal_busy, bus.ovr_i, bus.ovr_u);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset_l = 1'b0;
    bus.adc_i_raw = '0;
    bus.adc_u_raw = '0;
    bus.run_en  = 1'b0;
    bus.cal_req = 1'b0;
    bus.ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_I", bus.signal_adc_I, 0);
    chk("rst_U", bus.signal_adc_U, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.cal_busy, 0);
    chk("rst_ovr_i", bus.ovr_i, 0);
    chk("rst_ovr_u", bus.ovr_u, 0);
    reset_l = 1'b1;

    // IDLE bypass and tick timing.
    bus.adc_i_raw = 14'sd100;
    bus.adc_u_raw = -14'sd200;
    bus.run_en = 1'b1;
    wait_pulse(n);
    chk("first_latency", n, 51);
    chk("bypass_I", bus.signal_adc_I, 100);
    chk("bypass_U", bus.signal_adc_U, -200);
    @(negedge clk);
    chk("valid_one_cycle", bus.out_valid, 0);
    wait_pulse(n);
    chk("period", n, 49);

    // run_en low mid-count: no pulses, restart from zero.
    repeat (20) @(negedge clk);
    bus.run_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("no_pulse_disabled", pulses, 0);
    bus.run_en = 1'b1;
    wait_pulse(n);
    chk("reenable_latency", n, 51);

    // Calibration: I averages 10..13 -> 11, U averages -3,-3,-3,-2 -> -3 (floor).
    bus.adc_i_raw = 14'sd10;
    bus.adc_u_raw = -14'sd3;
    bus.cal_req = 1'b1;
    @(negedge clk);
    bus.cal_req = 1'b0;
    chk("cal_busy_entry", bus.cal_busy, 1);
    for (int k = 0; k < 4; k++) begin
      wait_pulse(n);
      chk("cal_out_I", bus.signal_adc_I, 0);
      chk("cal_out_U", bus.signal_adc_U, 0);
      chk("cal_busy_seq", bus.cal_busy, (k < 3) ? 1 : 0);
      bus.adc_i_raw = 14'(cal_i_tab[k]);
      bus.adc_u_raw = 14'(cal_u_tab[k]);
    end
    wait_pulse(n);
    chk("run_I", bus.signal_adc_I, 100);
    chk("run_U_floor", bus.signal_adc_U, 13);
    chk("run_busy", bus.cal_busy, 0);

    // Recalibrate I to -8000, then exercise saturation and sticky overrange.
    bus.adc_i_raw = -14'sd8000;
    bus.adc_u_raw = 14'sd0;
    bus.cal_req = 1'b1;
    @(negedge clk);
    bus.cal_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(n);
      bus.adc_i_raw = (k < 3) ? -14'sd8000 : 14'sd8191;
    end
    wait_pulse(n);
    chk("sat_I", bus.signal_adc_I, 8191);
    chk("sat_ovr_i", bus.ovr_i, 1);
    chk("sat_ovr_u", bus.ovr_u, 0);
    bus.adc_i_raw = 14'sd0;
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    chk("ovr_cleared", bus.ovr_i, 0);
    wait_pulse(n);
    chk("nosat_I", bus.signal_adc_I, 8000);
    chk("nosat_ovr_i", bus.ovr_i, 0);
    bus.adc_i_raw = 14'sd500;
    repeat (49) @(negedge clk);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    chk("clr_vs_set_valid", bus.out_valid, 1);
    chk("clr_vs_set_I", bus.signal_adc_I, 8191);
    chk("clr_vs_set_ovr", bus.ovr_i, 1);

    // Asynchronous reset in the middle of calibration.
    bus.adc_i_raw = 14'sd100;
    bus.adc_u_raw = 14'sd0;
    bus.cal_req = 1'b1;
    @(negedge clk);
    bus.cal_req = 1'b0;
    wait_pulse(n);
    chk("midcal_busy", bus.cal_busy, 1);
    #2 reset_l = 1'b0;
    #1;
    chk("arst_busy", bus.cal_busy, 0);
    chk("arst_I", bus.signal_adc_I, 0);
    chk("arst_ovr_i", bus.ovr_i, 0);
    chk("arst_valid", bus.out_valid, 0);
    @(negedge clk);
    reset_l = 1'b1;
    wait_pulse(n);
    chk("post_rst_latency", n, 51);
    chk("post_rst_bypass", bus.signal_adc_I, 100);
    chk("post_rst_busy", bus.cal_busy, 0);

    // Zero-offset calibration, then constant input of 50.
    bus.adc_i_raw = 14'sd0;
    bus.cal_req = 1'b1;
    @(negedge clk);
    bus.cal_req = 1'b0;
    for (int k = 0; k < 4; k++) wait_pulse(n);
    bus.adc_i_raw = 14'sd50;
`ifdef ADC_FRONTEND_TRACK_EN
    prev = 32'sd50;
    for (int k = 0; k < 40; k++) begin
      wait_pulse(n);
      chk("track_monotonic", (bus.signal_adc_I <= prev) ? 1 : 0, 1);
      prev = 32'(bus.signal_adc_I);
    end
    chk("track_decayed", (prev < 32'sd50) ? 1 : 0, 1);
`else
    prev = 32'sd50;
    for (int k = 0; k < 3; k++) begin
      wait_pulse(n);
      chk("frozen_offset", bus.signal_adc_I, prev);
    end
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
